// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if
//   Bundles the fetch-lookup, execute-update, redirect and performance
//   signals of the gshare branch predictor into one interface.
//   master : pipeline side (drives fetch/update, receives predictions)
//   slave  : predictor side (receives fetch/update, drives predictions)
//   Signals:
//     fetch_valid/fetch_pc                 lookup request
//     pred_hit/pred_taken/pred_target      same-cycle prediction
//     pred_ghr                             history snapshot for the branch
//     upd_*                                resolved branch from execute
//     flush/redirect_pc                    registered mispredict redirect
//     perf_branches/perf_mispredicts       saturating event counters
interface gshare_branch_predictor_if #(
  parameter int XLEN     = 32,
  parameter int GHR_BITS = 6
);
  logic                fetch_valid;
  logic [XLEN-1:0]     fetch_pc;
  logic                pred_hit;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;
  logic                upd_pred_taken;
  logic [XLEN-1:0]     upd_pred_target;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                flush;
  logic [XLEN-1:0]     redirect_pc;
  logic [31:0]         perf_branches;
  logic [31:0]         perf_mispredicts;

  modport master (
    output fetch_valid, fetch_pc,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target, upd_ghr,
    input  flush, redirect_pc, perf_branches, perf_mispredicts
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target, upd_ghr,
    output flush, redirect_pc, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   gshare direction predictor (2-bit counters indexed by PC xor global
//   history) with a tagged direct-mapped BTB. Lookup is combinational;
//   training, history repair and redirect generation happen on posedge clk.
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - synchronous active-high reset
//     bp   - slave side of gshare_branch_predictor_if (fetch lookup,
//            execute update, flush/redirect, performance counters)
module gshare_branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_BITS    = 6
) (
  input logic                      clk,
  input logic                      rst,
  gshare_branch_predictor_if.slave bp
);

  localparam int IDX   = $clog2(BHT_ENTRIES);
  localparam int BIDX  = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - BIDX - 2;

  // Shift one outcome into a history register; the cast keeps the low
  // GHR_BITS bits so this also works when GHR_BITS is 1.
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                   input logic b);
    return GHR_BITS'({h, b});
  endfunction

  logic [1:0]          bht_q [BHT_ENTRIES];
  logic [1:0]          bht_d [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]    btb_tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag_d [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target_q [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target_d [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic [31:0]         perf_branches_q, perf_branches_d;
  logic [31:0]         perf_mispredicts_q, perf_mispredicts_d;

  logic [IDX-1:0]      fetch_idx, upd_idx;
  logic [BIDX-1:0]     fetch_bidx, upd_bidx;
  logic [TAG_W-1:0]    fetch_tag, upd_tag;
  logic                hit, taken, mispredict;
  logic                unused_pc_bits;

  // The two byte-offset bits of an instruction PC never select anything.
  assign unused_pc_bits = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  assign fetch_idx  = bp.fetch_pc[IDX+1:2] ^ IDX'(ghr_q);
  assign upd_idx    = bp.upd_pc[IDX+1:2] ^ IDX'(bp.upd_ghr);
  assign fetch_bidx = bp.fetch_pc[BIDX+1:2];
  assign upd_bidx   = bp.upd_pc[BIDX+1:2];
  assign fetch_tag  = bp.fetch_pc[XLEN-1:BIDX+2];
  assign upd_tag    = bp.upd_pc[XLEN-1:BIDX+2];

  // Lookup reads only the registered tables, so a same-cycle write to the
  // same entry is not visible until the next cycle.
  assign hit   = btb_valid_q[fetch_bidx] && (btb_tag_q[fetch_bidx] == fetch_tag);
  assign taken = hit && bht_q[fetch_idx][1];

  assign bp.pred_hit    = hit;
  assign bp.pred_taken  = taken;
  assign bp.pred_target = taken ? btb_target_q[fetch_bidx] : bp.fetch_pc + XLEN'(4);
  assign bp.pred_ghr    = ghr_q;

  // A wrong direction, or a taken branch whose target differs from the
  // one fetch used, both require a redirect.
  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  // Table training: saturating counter step, BTB fill on taken branches only.
  always_comb begin
    bht_d        = bht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
        btb_valid_d[upd_bidx]  = 1'b1;
        btb_tag_d[upd_bidx]    = upd_tag;
        btb_target_d[upd_bidx] = bp.upd_target;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // History: speculative shift on a fetch hit, overridden by the repair
  // value built from the branch's own snapshot when execute mispredicts.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.fetch_valid && hit) ghr_d = shift_in(ghr_q, taken);
    if (mispredict)            ghr_d = shift_in(bp.upd_ghr, bp.upd_taken);
  end

  // Redirect and performance counters; redirect_pc keeps its last value
  // between mispredicts.
  always_comb begin
    flush_d            = mispredict;
    redirect_pc_d      = redirect_pc_q;
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (mispredict)
      redirect_pc_d = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
    if (bp.upd_valid && (perf_branches_q != 32'hFFFF_FFFF))
      perf_branches_d = perf_branches_q + 32'd1;
    if (mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF))
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
  end

  // Resettable state; an update presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      btb_valid_q        <= '0;
      ghr_q              <= '0;
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      bht_q              <= bht_d;
      btb_valid_q        <= btb_valid_d;
      ghr_q              <= ghr_d;
      flush_q            <= flush_d;
      redirect_pc_q      <= redirect_pc_d;
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  // BTB payload needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
    end
  end

  assign bp.flush            = flush_q;
  assign bp.redirect_pc      = redirect_pc_q;
  assign bp.perf_branches    = perf_branches_q;
  assign bp.perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor
//   Directed bench for gshare_branch_predictor with default parameters.
//   A table-level model tracks counters, BTB contents, history, redirect
//   and counters; a negedge process compares every DUT output with it,
//   and the directed sequence adds hand-computed literal expectations.
module tb_gshare_branch_predictor;

  logic clk = 1'b0;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  gshare_branch_predictor_if #(.XLEN(32), .GHR_BITS(6)) bus ();

  gshare_branch_predictor #(
    .XLEN(32), .BHT_ENTRIES(64), .BTB_ENTRIES(16), .GHR_BITS(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_bht [64];
  bit          m_bv  [16];
  logic [31:0] m_btag[16];
  logic [31:0] m_btgt[16];
  int          m_ghr;
  bit          m_flush;
  logic [31:0] m_redirect;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  bit          model_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit hit,
                               output bit taken, output logic [31:0] target);
    int idx, bi;
    idx    = int'((pc >> 2) % 64) ^ m_ghr;
    bi     = int'((pc >> 2) % 16);
    hit    = m_bv[bi] && (m_btag[bi] == (pc >> 6));
    taken  = hit && (m_bht[idx] >= 2);
    target = taken ? m_btgt[bi] : 32'(pc + 32'd4);
  endtask

  // Model update on each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit          h, t, mis;
    logic [31:0] tg;
    int          new_ghr, ui, bi;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      for (int i = 0; i < 16; i++) m_bv[i] <= 1'b0;
      m_ghr       <= 0;
      m_flush     <= 1'b0;
      m_redirect  <= 32'd0;
      m_br        <= 32'd0;
      m_mis       <= 32'd0;
      model_ready <= 1'b1;
    end else if (model_ready) begin
      model_predict(bus.fetch_pc, h, t, tg);
      new_ghr = m_ghr;
      if (bus.fetch_valid && h) new_ghr = (m_ghr * 2 + int'(t)) % 64;
      mis = bus.upd_valid &&
            ((bus.upd_taken != bus.upd_pred_taken) ||
             (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
      if (bus.upd_valid) begin
        ui = int'((bus.upd_pc >> 2) % 64) ^ int'(bus.upd_ghr);
        bi = int'((bus.upd_pc >> 2) % 16);
        if (bus.upd_taken) begin
          m_bht[ui] <= (m_bht[ui] == 3) ? 3 : m_bht[ui] + 1;
          m_bv[bi]   <= 1'b1;
          m_btag[bi] <= bus.upd_pc >> 6;
          m_btgt[bi] <= bus.upd_target;
        end else begin
          m_bht[ui] <= (m_bht[ui] == 0) ? 0 : m_bht[ui] - 1;
        end
        if (m_br != 32'hFFFF_FFFF) m_br <= m_br + 32'd1;
      end
      if (mis) begin
        new_ghr = (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % 64;
        m_redirect <= bus.upd_taken ? bus.upd_target : 32'(bus.upd_pc + 32'd4);
        if (m_mis != 32'hFFFF_FFFF) m_mis <= m_mis + 32'd1;
      end
      m_flush <= mis;
      m_ghr   <= new_ghr;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit          h, t;
    logic [31:0] tg;
    if (model_ready) begin
      model_predict(bus.fetch_pc, h, t, tg);
      checkOutput("model pred_hit", {31'b0, bus.pred_hit}, {31'b0, h});
      checkOutput("model pred_taken", {31'b0, bus.pred_taken}, {31'b0, t});
      checkOutput("model pred_target", bus.pred_target, tg);
      checkOutput("model pred_ghr", {26'b0, bus.pred_ghr}, 32'(m_ghr));
      checkOutput("model flush", {31'b0, bus.flush}, {31'b0, m_flush});
      checkOutput("model redirect_pc", bus.redirect_pc, m_redirect);
      checkOutput("model perf_branches", bus.perf_branches, m_br);
      checkOutput("model perf_mispredicts", bus.perf_mispredicts, m_mis);
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input bit r, input bit fv, input logic [31:0] fpc,
                               input bit uv, input logic [31:0] upc, input bit ut,
                               input logic [31:0] utgt, input bit upt,
                               input logic [31:0] uptgt, input logic [5:0] ughr);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.fetch_valid     = fv;
    bus.fetch_pc        = fpc;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;
    bus.upd_ghr         = ughr;
  endtask

  task automatic idle(input bit fv, input logic [31:0] fpc);
    applyStimulus(1'b0, fv, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.fetch_valid     = 1'b0;
    bus.fetch_pc        = 32'h4;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = 32'h0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = 32'h0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = 32'h0;
    bus.upd_ghr         = 6'h0;

    // Reset held for two edges
    applyStimulus(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0);
    applyStimulus(1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0);

    // Post-reset lookup of 0x4
    idle(1'b1, 32'h4);
    @(negedge clk);
    checkOutput("reset pred_hit", {31'b0, bus.pred_hit}, 32'd0);
    checkOutput("reset pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    checkOutput("reset pred_target", bus.pred_target, 32'h8);
    checkOutput("reset pred_ghr", {26'b0, bus.pred_ghr}, 32'h0);
    checkOutput("reset flush", {31'b0, bus.flush}, 32'd0);
    checkOutput("reset perf_branches", bus.perf_branches, 32'd0);
    checkOutput("reset perf_mispredicts", bus.perf_mispredicts, 32'd0);

    // Cold mispredict at 0x4 -> taken to 0x14
    applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 32'h4, 1'b1, 32'h14, 1'b0, 32'h8, 6'h3F);

    // Trained hit on 0x4, with the flush from the cold mispredict
    idle(1'b1, 32'h4);
    @(negedge clk);
    checkOutput("cold flush", {31'b0, bus.flush}, 32'd1);
    checkOutput("cold redirect_pc", bus.redirect_pc, 32'h14);
    checkOutput("cold perf_mispredicts", bus.perf_mispredicts, 32'd1);
    checkOutput("cold model BHT[0x3E]", 32'(m_bht[62]), 32'd2);
    checkOutput("cold model BTB[1] valid", {31'b0, m_bv[1]}, 32'd1);
    checkOutput("hit pred_hit", {31'b0, bus.pred_hit}, 32'd1);
    checkOutput("hit pred_taken", {31'b0, bus.pred_taken}, 32'd1);
    checkOutput("hit pred_target", bus.pred_target, 32'h14);
    checkOutput("hit pred_ghr", {26'b0, bus.pred_ghr}, 32'h3F);

    // Correctly predicted taken branch fed back
    applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 32'h4, 1'b1, 32'h14, 1'b1, 32'h14, 6'h3F);

    // Non-branch fetch of 0x14
    idle(1'b1, 32'h14);
    @(negedge clk);
    checkOutput("trained flush", {31'b0, bus.flush}, 32'd0);
    checkOutput("trained perf_branches", bus.perf_branches, 32'd2);
    checkOutput("trained perf_mispredicts", bus.perf_mispredicts, 32'd1);
    checkOutput("trained model BHT[0x3E]", 32'(m_bht[62]), 32'd3);
    checkOutput("nonbranch pred_hit", {31'b0, bus.pred_hit}, 32'd0);
    checkOutput("nonbranch pred_target", bus.pred_target, 32'h18);

    // Three not-taken updates at 0x4 walk the counter down to 00
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h14, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h8, 6'h3F);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("nonbranch ghr held", {26'b0, bus.pred_ghr}, 32'h3F);
      end
    end

    idle(1'b1, 32'h4);
    @(negedge clk);
    checkOutput("hyst model BHT[0x3E]", 32'(m_bht[62]), 32'd0);
    checkOutput("hyst pred_hit", {31'b0, bus.pred_hit}, 32'd1);
    checkOutput("hyst pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    checkOutput("hyst pred_target", bus.pred_target, 32'h8);
    checkOutput("hyst perf_branches", bus.perf_branches, 32'd5);

    // Fetch hit and mispredict in the same cycle: repair wins
    applyStimulus(1'b0, 1'b1, 32'h4, 1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 32'h24, 6'h15);
    @(negedge clk);
    checkOutput("simul pred_ghr before", {26'b0, bus.pred_ghr}, 32'h3E);

    // Back-to-back mispredicts: not-taken, then wrong target
    applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 32'h50, 6'h00);
    @(negedge clk);
    checkOutput("repair pred_ghr", {26'b0, bus.pred_ghr}, 32'h2B);
    checkOutput("repair flush", {31'b0, bus.flush}, 32'd1);
    checkOutput("repair redirect_pc", bus.redirect_pc, 32'h40);

    applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h80, 6'h01);
    @(negedge clk);
    checkOutput("b2b first flush", {31'b0, bus.flush}, 32'd1);
    checkOutput("b2b first redirect_pc", bus.redirect_pc, 32'h34);

    idle(1'b0, 32'h4);
    @(negedge clk);
    checkOutput("b2b second flush", {31'b0, bus.flush}, 32'd1);
    checkOutput("b2b second redirect_pc", bus.redirect_pc, 32'h100);
    checkOutput("b2b pred_ghr", {26'b0, bus.pred_ghr}, 32'h03);
    checkOutput("b2b perf_mispredicts", bus.perf_mispredicts, 32'd4);

    idle(1'b0, 32'h4);
    @(negedge clk);
    checkOutput("pulse ends flush", {31'b0, bus.flush}, 32'd0);
    checkOutput("redirect holds", bus.redirect_pc, 32'h100);

    // Reset asserted during a fetch hit plus mispredict
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b1, 32'h4, 1'b1, 32'h14, 1'b0, 32'h8, 6'h2A);
    @(negedge clk);
    checkOutput("prereset pred_hit", {31'b0, bus.pred_hit}, 32'd1);

    idle(1'b1, 32'h20);
    @(negedge clk);
    checkOutput("midreset pred_ghr", {26'b0, bus.pred_ghr}, 32'h0);
    checkOutput("midreset flush", {31'b0, bus.flush}, 32'd0);
    checkOutput("midreset redirect_pc", bus.redirect_pc, 32'h0);
    checkOutput("midreset perf_branches", bus.perf_branches, 32'd0);
    checkOutput("midreset perf_mispredicts", bus.perf_mispredicts, 32'd0);
    checkOutput("midreset pred_hit", {31'b0, bus.pred_hit}, 32'd0);
    checkOutput("midreset pred_target", bus.pred_target, 32'h24);

    // PC wrap-around on the fall-through target
    idle(1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrap pred_hit", {31'b0, bus.pred_hit}, 32'd0);
    checkOutput("wrap pred_target", bus.pred_target, 32'h0);

    idle(1'b0, 32'h0);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
